// File: rtl/rtc_read_sequencer.sv
// RTC read sequencer: fetches the nine time/timer registers over the
// multiplexed RTC bus and publishes them atomically to the display path.
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   en                 bus grant / block enable
//   start              one-cycle read request
//   busy               high in any state other than IDLE
//   done               one-cycle pulse when rd_time/rd_timer update
//   rtc_cs_n/ad_n      chip select (low), 0=address / 1=data phase
//   rtc_wr_n/rd_n      address latch strobe (low), read strobe (low)
//   rtc_data_out/oe    address onto bus, drive enable for top tristate
//   rtc_data_in        bus read-back
//   rd_time            {year,month,day,hour,min,seg}, raw BCD
//   rd_timer           {thour,tmin,tseg}, raw BCD
module rtc_read_sequencer #(
    parameter int PHASE_CYCLES   = 10,
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rtc_cs_n,
    output logic        rtc_ad_n,
    output logic        rtc_wr_n,
    output logic        rtc_rd_n,
    output logic [7:0]  rtc_data_out,
    output logic        rtc_data_oe,
    input  logic [7:0]  rtc_data_in,
    output logic [47:0] rd_time,
    output logic [23:0] rd_timer
);

    localparam int RW =
        (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam bit REF_EN = (REFRESH_CYCLES != 0);
    localparam logic [7:0] PH_LAST = 8'(PHASE_CYCLES - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_DATA,
        S_GAP2,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [7:0]      r_phase;
    logic [7:0]      w_phase_nx;
    logic [3:0]      r_idx;
    logic [3:0]      w_idx_nx;
    logic [RW-1:0]   r_ref;
    logic [RW-1:0]   w_ref_nx;
    logic [8:0][7:0] r_shadow;

    logic w_ph_end;
    logic w_tick;
    logic w_go;
    logic w_sample;
    logic w_publish;

    logic       r_busy;
    logic       r_done;
    logic       r_cs_n;
    logic       r_ad_n;
    logic       r_wr_n;
    logic       r_rd_n;
    logic       r_oe;
    logic [7:0] r_dout;
    logic [47:0] r_time;
    logic [23:0] r_timer;

    logic       w_cs_n;
    logic       w_ad_n;
    logic       w_wr_n;
    logic       w_rd_n;
    logic       w_oe;
    logic [7:0] w_dout;

    function automatic logic [7:0] addr_of(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = 8'h21;
            4'd1:    a = 8'h22;
            4'd2:    a = 8'h23;
            4'd3:    a = 8'h24;
            4'd4:    a = 8'h25;
            4'd5:    a = 8'h26;
            4'd6:    a = 8'h41;
            4'd7:    a = 8'h42;
            4'd8:    a = 8'h43;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Next-state logic. Losing the bus grant aborts any read at once.
    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_idx_nx   = r_idx;
        w_ref_nx   = r_ref;
        w_sample   = 1'b0;
        w_publish  = 1'b0;
        w_ph_end   = (r_phase == PH_LAST);
        w_tick     = REF_EN && (r_ref == REF_LAST);
        w_go       = en && (start || w_tick);

        if (r_state != S_IDLE && !en) begin
            w_state_nx = S_IDLE;
            w_phase_nx = '0;
            w_idx_nx   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        w_state_nx = S_ADDR;
                        w_phase_nx = '0;
                        w_idx_nx   = '0;
                        w_ref_nx   = '0;
                    end else if (en && REF_EN) begin
                        w_ref_nx = r_ref + RW'(1);
                    end
                end
                S_ADDR: begin
                    w_phase_nx = w_ph_end ? 8'd0 : r_phase + 8'd1;
                    if (w_ph_end) w_state_nx = S_GAP1;
                end
                S_GAP1: begin
                    w_phase_nx = w_ph_end ? 8'd0 : r_phase + 8'd1;
                    if (w_ph_end) w_state_nx = S_DATA;
                end
                S_DATA: begin
                    w_phase_nx = w_ph_end ? 8'd0 : r_phase + 8'd1;
                    // Latest sample point gives the RTC the full phase.
                    w_sample   = w_ph_end;
                    if (w_ph_end) w_state_nx = S_GAP2;
                end
                S_GAP2: begin
                    w_phase_nx = w_ph_end ? 8'd0 : r_phase + 8'd1;
                    if (w_ph_end) begin
                        if (r_idx == 4'd8) begin
                            w_state_nx = S_DONE;
                        end else begin
                            w_idx_nx   = r_idx + 4'd1;
                            w_state_nx = S_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    w_publish  = 1'b1;
                    w_state_nx = S_IDLE;
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_phase_nx = '0;
                    w_idx_nx   = '0;
                end
            endcase
        end
    end

    // Bus strobes decoded from the next state so they register
    // in step with the state itself.
    always_comb begin
        w_cs_n = 1'b1;
        w_ad_n = 1'b1;
        w_wr_n = 1'b1;
        w_rd_n = 1'b1;
        w_oe   = 1'b0;
        w_dout = 8'h00;
        case (w_state_nx)
            S_ADDR: begin
                w_cs_n = 1'b0;
                w_ad_n = 1'b0;
                w_wr_n = 1'b0;
                w_oe   = 1'b1;
                w_dout = addr_of(w_idx_nx);
            end
            S_DATA: begin
                w_cs_n = 1'b0;
                w_rd_n = 1'b0;
            end
            default: begin
                w_cs_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_idx    <= '0;
            r_ref    <= '0;
            r_shadow <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_ad_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_rd_n   <= 1'b1;
            r_oe     <= 1'b0;
            r_dout   <= 8'h00;
            r_time   <= '0;
            r_timer  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            r_idx   <= w_idx_nx;
            r_ref   <= w_ref_nx;
            r_busy  <= (w_state_nx != S_IDLE);
            r_done  <= w_publish;
            r_cs_n  <= w_cs_n;
            r_ad_n  <= w_ad_n;
            r_wr_n  <= w_wr_n;
            r_rd_n  <= w_rd_n;
            r_oe    <= w_oe;
            r_dout  <= w_dout;
            if (w_sample) begin
                r_shadow[r_idx] <= rtc_data_in;
            end
            if (w_publish) begin
                r_time  <= r_shadow[5:0];
                r_timer <= r_shadow[8:6];
            end
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign rtc_cs_n     = r_cs_n;
    assign rtc_ad_n     = r_ad_n;
    assign rtc_wr_n     = r_wr_n;
    assign rtc_rd_n     = r_rd_n;
    assign rtc_data_oe  = r_oe;
    assign rtc_data_out = r_dout;
    assign rd_time      = r_time;
    assign rd_timer     = r_timer;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed bench for rtc_read_sequencer: one instance without
// auto-refresh (A) and one with a 20-clock refresh period (B).
module tb_rtc_read_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        enA, startA, busyA, doneA;
    logic        csA, adA, wrA, rdA, oeA;
    logic [7:0]  doutA, dinA, addrA, offA;
    logic [47:0] timeA;
    logic [23:0] timerA;

    logic        enB, startB, busyB, doneB;
    logic        csB, adB, wrB, rdB, oeB;
    logic [7:0]  doutB, dinB, addrB;
    logic [47:0] timeB;
    logic [23:0] timerB;

    int nchk = 0;
    int nfail = 0;
    int ndA = 0, ndB = 0, violA = 0, violB = 0;

    logic [7:0] tbl [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                            8'h26, 8'h41, 8'h42, 8'h43};

    rtc_read_sequencer #(
        .PHASE_CYCLES(2),
        .REFRESH_CYCLES(0)
    ) u_a (
        .clock(clock), .reset(reset), .en(enA), .start(startA),
        .busy(busyA), .done(doneA),
        .rtc_cs_n(csA), .rtc_ad_n(adA), .rtc_wr_n(wrA), .rtc_rd_n(rdA),
        .rtc_data_out(doutA), .rtc_data_oe(oeA), .rtc_data_in(dinA),
        .rd_time(timeA), .rd_timer(timerA)
    );

    rtc_read_sequencer #(
        .PHASE_CYCLES(2),
        .REFRESH_CYCLES(20)
    ) u_b (
        .clock(clock), .reset(reset), .en(enB), .start(startB),
        .busy(busyB), .done(doneB),
        .rtc_cs_n(csB), .rtc_ad_n(adB), .rtc_wr_n(wrB), .rtc_rd_n(rdB),
        .rtc_data_out(doutB), .rtc_data_oe(oeB), .rtc_data_in(dinB),
        .rd_time(timeB), .rd_timer(timerB)
    );

    // RTC model: latches the address, returns 0x10 + register index + offset.
    function automatic logic [7:0] rtc_val(input logic [7:0] a,
                                           input logic [7:0] off);
        logic [7:0] i;
        i = a[6] ? (a - 8'h41 + 8'd6) : (a - 8'h21);
        return 8'h10 + i + off;
    endfunction

    always @(posedge clock) begin
        if (!csA && !adA && !wrA) addrA <= doutA;
        if (!csB && !adB && !wrB) addrB <= doutB;
    end
    assign dinA = rtc_val(addrA, offA);
    assign dinB = rtc_val(addrB, 8'h00);

    always @(negedge clock) begin
        if (doneA) ndA <= ndA + 1;
        if (doneB) ndB <= ndB + 1;
        if (!rdA && oeA) violA <= violA + 1;
        if (!rdB && oeB) violB <= violB + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {done,busy,cs_n,ad_n,wr_n,rd_n,oe,data_out} for cycle j of a read
    function automatic logic [14:0] exp_bus(input int j);
        int w;
        w = j % 8;
        if (j == 72) return {2'b01, 5'b11110, 8'h00};
        case (w)
            0, 1:    return {2'b01, 5'b00011, tbl[j/8]};
            4, 5:    return {2'b01, 5'b01100, 8'h00};
            default: return {2'b01, 5'b11110, 8'h00};
        endcase
    endfunction

    initial begin
        int k;
        int n0;
        logic flag;
        logic [7:0] dm;

        enA = 1'b1; startA = 1'b0; offA = 8'h00;
        enB = 1'b1; startB = 1'b0;
        repeat (3) @(negedge clock);

        chk("rst_a_bus", {busyA, doneA, csA, adA, wrA, rdA, oeA, doutA},
            {2'b00, 4'b1111, 1'b0, 8'h00});
        chk("rst_a_time", timeA, 0);
        chk("rst_a_timer", timerA, 0);
        chk("rst_b_bus", {busyB, doneB, csB, adB, wrB, rdB, oeB, doutB},
            {2'b00, 4'b1111, 1'b0, 8'h00});
        reset = 1'b0;

        // Auto-refresh timing on B
        k = 0;
        do begin @(negedge clock); k++; end while (csB && k < 200);
        chk("t3_first_read", k, 20);
        k = 0;
        do begin @(negedge clock); k++; end while (!doneB && k < 200);
        chk("t3_latency", k, 73);
        chk("t3_time", timeB, 48'h151413121110);
        chk("t3_timer", timerB, 24'h181716);
        k = 0;
        do begin @(negedge clock); k++; end while (csB && k < 200);
        chk("t3_next_read", k, 20);
        k = 0;
        do begin @(negedge clock); k++; end while (!doneB && k < 200);
        chk("t3_latency2", k, 73);

        // en low in IDLE freezes the refresh count at 5
        repeat (5) @(negedge clock);
        enB = 1'b0;
        flag = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (busyB) flag = 1'b1;
        end
        chk("t3_hold_idle", flag, 0);
        enB = 1'b1;
        k = 0;
        do begin @(negedge clock); k++; end while (csB && k < 200);
        chk("t3_hold_resume", k, 15);
        k = 0;
        do begin @(negedge clock); k++; end while (!doneB && k < 200);
        chk("t3_latency3", k, 73);

        // start coincident with the refresh tick
        repeat (19) @(negedge clock);
        n0 = ndB;
        startB = 1'b1;
        @(negedge clock);
        startB = 1'b0;
        chk("t5_coinc_start", csB, 0);
        repeat (90) @(negedge clock);
        chk("t5_coinc_done", ndB - n0, 1);
        enB = 1'b0;

        // Single read on A: cycle-by-cycle bus protocol and latency
        @(negedge clock);
        startA = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        for (int j = 0; j < 73; j++) begin
            dm = ((j % 8) < 2 && j < 72) ? doutA : 8'h00;
            chk($sformatf("t2_bus_%0d", j),
                {doneA, busyA, csA, adA, wrA, rdA, oeA, dm}, exp_bus(j));
            @(negedge clock);
        end
        chk("t1_done", doneA, 1);
        chk("t1_time", timeA, 48'h151413121110);
        chk("t1_timer", timerA, 24'h181716);
        @(negedge clock);
        chk("t1_done_pulse", {doneA, busyA}, 2'b00);

        // start while busy is ignored
        offA = 8'h20;
        n0 = ndA;
        startA = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        repeat (10) @(negedge clock);
        startA = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        chk("t5_busy", busyA, 1);
        k = 0;
        do begin @(negedge clock); k++; end while (!doneA && k < 200);
        chk("t5_latency", k, 62);
        chk("t5_time", timeA, 48'h353433323130);
        chk("t5_timer", timerA, 24'h383736);
        repeat (80) @(negedge clock);
        chk("t5_one_done", ndA - n0, 1);
        chk("t5_idle", busyA, 0);

        // en drops in the idx=4 DATA phase
        offA = 8'h40;
        startA = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        repeat (36) @(negedge clock);
        chk("t4_in_data", {csA, adA, rdA, doutA}, {3'b010, 8'h00});
        enA = 1'b0;
        n0 = ndA;
        @(negedge clock);
        chk("t4_release", {busyA, csA, rdA, oeA}, 4'b0110);
        chk("t4_time_kept", timeA, 48'h353433323130);
        chk("t4_timer_kept", timerA, 24'h383736);
        startA = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        repeat (20) @(negedge clock);
        chk("t4_no_done", ndA - n0, 0);
        chk("t4_en0_start_ignored", busyA, 0);

        enA = 1'b1;
        startA = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        k = 0;
        do begin @(negedge clock); k++; end while (!doneA && k < 200);
        chk("t4_restart_latency", k, 73);
        chk("t4_restart_time", timeA, 48'h555453525150);
        chk("t4_restart_timer", timerA, 24'h585756);

        // reset during GAP1
        @(negedge clock);
        startA = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        repeat (2) @(negedge clock);
        chk("t6_gap1", {busyA, csA, oeA}, 3'b110);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_reset", {busyA, doneA, csA, rdA, oeA, doutA},
            {5'b00110, 8'h00});
        chk("t6_time", timeA, 0);
        chk("t6_timer", timerA, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        chk("oe_rd_excl_a", violA, 0);
        chk("oe_rd_excl_b", violB, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
